// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if: control sequencer <-> datapath/memory signal bundle
interface mc_ctrl_fsm_if #(parameter int CNT_W = 32);
    logic [5:0]       op;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             iord;
    logic             memwrite;
    logic             irwrite;
    logic             pcen;
    logic             regdst;
    logic             memtoreg;
    logic             regwrite;
    logic             alusrca;
    logic [1:0]       alusrcb;
    logic [1:0]       pcsrc;
    logic [1:0]       aluop;
    logic             illegal_op;
    logic             bus_err;
    logic             instr_done;
    logic [CNT_W-1:0] instret;
    modport master (
        input  op, zero, mem_ready,
        output mem_req, iord, memwrite, irwrite, pcen, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, aluop, illegal_op, bus_err, instr_done, instret
    );
    modport slave (
        output op, zero, mem_ready,
        input  mem_req, iord, memwrite, irwrite, pcen, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, aluop, illegal_op, bus_err, instr_done, instret
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS control sequencer with trap, memory timeout and retire counter
module mc_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input logic           clk,
    input logic           reset_n,
    mc_ctrl_fsm_if.master ctl
);
    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE,
        ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, TRAP, BUSERR
    } state_t;
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
    localparam int TW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
    state_t        state, state_n;
    logic [TW-1:0] wcnt;
    logic          waiting, timeout;
    assign waiting = (state == FETCH || state == MEMRD || state == MEMWR) && !ctl.mem_ready;
    assign timeout = MEM_TIMEOUT != 0 && waiting && wcnt == TW'(MEM_TIMEOUT - 1);
    // state register
    always_ff @(posedge clk) state <= !reset_n ? IDLE : state_n;
    // memory wait counter (cleared on any state change) and retired-instruction counter
    always_ff @(posedge clk)
        if (!reset_n) begin
            wcnt        <= '0;
            ctl.instret <= '0;
        end else begin
            wcnt        <= state_n != state ? '0 : wcnt + TW'(waiting);
            ctl.instret <= ctl.instret + CNT_W'(ctl.instr_done);
        end
    // next-state: a late mem_ready beats the timeout; TRAP/BUSERR hold until reset
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = FETCH;
            FETCH:   state_n = ctl.mem_ready ? DECODE : timeout ? BUSERR : FETCH;
            DECODE:  state_n = ctl.op == OP_R ? EXECUTE :
                               (ctl.op == OP_LW || ctl.op == OP_SW) ? MEMADR :
                               ctl.op == OP_BEQ ? BRANCH :
                               ctl.op == OP_ADDI ? ADDIEX :
                               ctl.op == OP_J ? JUMP : TRAP;
            MEMADR:  state_n = ctl.op == OP_LW ? MEMRD : MEMWR;
            MEMRD:   state_n = ctl.mem_ready ? MEMWB : timeout ? BUSERR : MEMRD;
            MEMWR:   state_n = ctl.mem_ready ? FETCH : timeout ? BUSERR : MEMWR;
            EXECUTE: state_n = ALUWB;
            ADDIEX:  state_n = ADDIWB;
            MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: state_n = FETCH;
            default: state_n = state;
        endcase
    end
    // Moore outputs, except the FETCH/BRANCH PC enables and the MEMWR retire pulse
    always_comb begin
        ctl.mem_req    = 1'b0;
        ctl.iord       = 1'b0;
        ctl.memwrite   = 1'b0;
        ctl.irwrite    = 1'b0;
        ctl.pcen       = 1'b0;
        ctl.regdst     = 1'b0;
        ctl.memtoreg   = 1'b0;
        ctl.regwrite   = 1'b0;
        ctl.alusrca    = 1'b0;
        ctl.alusrcb    = 2'b00;
        ctl.pcsrc      = 2'b00;
        ctl.aluop      = 2'b00;
        ctl.illegal_op = 1'b0;
        ctl.bus_err    = 1'b0;
        ctl.instr_done = 1'b0;
        case (state)
            FETCH: begin
                ctl.mem_req = 1'b1;
                ctl.alusrcb = 2'b01;
                ctl.irwrite = ctl.mem_ready;
                ctl.pcen    = ctl.mem_ready;
            end
            DECODE:  ctl.alusrcb = 2'b11;
            MEMADR, ADDIEX: begin
                ctl.alusrca = 1'b1;
                ctl.alusrcb = 2'b10;
            end
            MEMRD: begin
                ctl.mem_req = 1'b1;
                ctl.iord    = 1'b1;
            end
            MEMWB: begin
                ctl.regwrite   = 1'b1;
                ctl.memtoreg   = 1'b1;
                ctl.instr_done = 1'b1;
            end
            MEMWR: begin
                ctl.mem_req    = 1'b1;
                ctl.iord       = 1'b1;
                ctl.memwrite   = 1'b1;
                ctl.instr_done = ctl.mem_ready;
            end
            EXECUTE: begin
                ctl.alusrca = 1'b1;
                ctl.aluop   = 2'b10;
            end
            ALUWB: begin
                ctl.regwrite   = 1'b1;
                ctl.regdst     = 1'b1;
                ctl.instr_done = 1'b1;
            end
            BRANCH: begin
                ctl.alusrca    = 1'b1;
                ctl.aluop      = 2'b01;
                ctl.pcsrc      = 2'b01;
                ctl.pcen       = ctl.zero;
                ctl.instr_done = 1'b1;
            end
            ADDIWB: begin
                ctl.regwrite   = 1'b1;
                ctl.instr_done = 1'b1;
            end
            JUMP: begin
                ctl.pcsrc      = 2'b10;
                ctl.pcen       = 1'b1;
                ctl.instr_done = 1'b1;
            end
            TRAP:    ctl.illegal_op = 1'b1;
            BUSERR:  ctl.bus_err = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed + randomized instruction streams checked against a phase-level model
module tb_mc_ctrl_fsm;
    localparam int T = 4;
    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] exp_cnt = '0;
    int          checks = 0;
    int          failures = 0;
    mc_ctrl_fsm_if #(.CNT_W(32)) bus ();
    mc_ctrl_fsm #(.MEM_TIMEOUT(T), .CNT_W(32)) dut (.clk(clk), .reset_n(reset_n), .ctl(bus));
    always #5 clk = ~clk;
    function automatic logic [17:0] w(input logic mr, io, mwr, irw, pe, rd, m2r, rw, asa,
                                      input logic [1:0] asb, ps, ao, input logic ill, be, dn);
        return {mr, io, mwr, irw, pe, rd, m2r, rw, asa, asb, ps, ao, ill, be, dn};
    endfunction
    function automatic logic [17:0] obs();
        return {bus.mem_req, bus.iord, bus.memwrite, bus.irwrite, bus.pcen, bus.regdst,
                bus.memtoreg, bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.aluop,
                bus.illegal_op, bus.bus_err, bus.instr_done};
    endfunction
    function automatic logic [17:0] w_fetch(input logic r);
        return w(1, 0, 0, r, r, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0);
    endfunction
    function automatic logic [17:0] w_memwr(input logic r);
        return w(1, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, r);
    endfunction
    function automatic logic [17:0] w_branch(input logic z);
        return w(0, 0, 0, 0, z, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0, 0, 1);
    endfunction
    localparam logic [17:0] W_IDLE = '0;
    logic [17:0] w_decode, w_memadr, w_memrd, w_memwb, w_exec, w_aluwb;
    logic [17:0] w_addiex, w_addiwb, w_jump, w_trap, w_buserr;
    initial begin
        w_decode = w(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0, 0);
        w_memadr = w(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0);
        w_memrd  = w(1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        w_memwb  = w(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1);
        w_exec   = w(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b10, 0, 0, 0);
        w_aluwb  = w(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1);
        w_addiex = w(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0);
        w_addiwb = w(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1);
        w_jump   = w(0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 0, 1);
        w_trap   = w(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0);
        w_buserr = w(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0);
    end
    // one clock: compare outputs at the falling edge, then advance the retire model
    task automatic step(input logic [17:0] e, input string tag);
        logic [17:0] o;
        @(negedge clk);
        o = obs();
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s ctrl obs=%h exp=%h", tag, o, e);
        end
        checks++;
        assert (bus.instret === exp_cnt) else begin
            failures++;
            $error("FAIL %s instret obs=%0d exp=%0d", tag, bus.instret, exp_cnt);
        end
        @(posedge clk);
        #1;
        if (!reset_n) exp_cnt = '0;
        else if (e[0]) exp_cnt++;
    endtask
    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_cnt = '0;
        bus.mem_ready = 1'(($urandom));
        step(W_IDLE, "idle");
    endtask
    // memory phase: kind 0 fetch, 1 read, 2 write; waits = cycles with mem_ready low
    task automatic mem_wait(input int kind, input int waits, output bit err);
        logic r;
        err = 0;
        for (int i = 0; i < T + 8; i++) begin
            r = i >= waits;
            bus.mem_ready = r;
            step(kind == 0 ? w_fetch(r) : kind == 1 ? w_memrd : w_memwr(r),
                 kind == 0 ? "fetch" : kind == 1 ? "memrd" : "memwr");
            if (r) return;
            if (i == T - 1) begin
                err = 1;
                return;
            end
        end
    endtask
    task automatic hold(input logic [17:0] e, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            bus.op = 6'($urandom);
            bus.zero = 1'($urandom);
            bus.mem_ready = 1'($urandom);
            step(e, tag);
        end
    endtask
    task automatic run_instr(input logic [5:0] o, input logic z, input int fw, input int mw,
                             output bit stop);
        bit err;
        stop = 0;
        bus.op = o;
        bus.zero = z;
        mem_wait(0, fw, err);
        if (err) begin
            hold(w_buserr, 5, "buserr");
            stop = 1;
            return;
        end
        bus.mem_ready = 1'($urandom);
        step(w_decode, "decode");
        case (o)
            R: begin step(w_exec, "exec"); step(w_aluwb, "aluwb"); end
            LW, SW: begin
                step(w_memadr, "memadr");
                mem_wait(o == LW ? 1 : 2, mw, err);
                if (err) begin
                    hold(w_buserr, 5, "buserr");
                    stop = 1;
                    return;
                end
                if (o == LW) step(w_memwb, "memwb");
            end
            BEQ: step(w_branch(z), "branch");
            ADDI: begin step(w_addiex, "addiex"); step(w_addiwb, "addiwb"); end
            J: step(w_jump, "jump");
            default: begin
                hold(w_trap, 6, "trap");
                stop = 1;
            end
        endcase
    endtask
    function automatic bit legal(input logic [5:0] o);
        return o == R || o == LW || o == SW || o == BEQ || o == ADDI || o == J;
    endfunction
    initial begin
        bit stop, err;
        logic [5:0] ops [6];
        logic [5:0] o;
        int fw, mw;
        ops = '{R, LW, SW, BEQ, ADDI, J};
        bus.op = '0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        do_reset();
        run_instr(R, 0, 0, 0, stop);
        checks++;
        assert (bus.instret === 32'd1) else begin
            failures++;
            $error("FAIL rtype_instret obs=%0d exp=1", bus.instret);
        end
        run_instr(LW, 0, 0, 3, stop);
        run_instr(BEQ, 1, 0, 0, stop);
        run_instr(BEQ, 0, 0, 0, stop);
        run_instr(ADDI, 0, 2, 0, stop);
        run_instr(J, 0, T - 1, 0, stop);
        run_instr(SW, 0, 1, 2, stop);
        run_instr(6'b111111, 0, 0, 0, stop);
        hold(w_trap, 14, "trap_hold");
        do_reset();
        run_instr(J, 0, T, 0, stop);
        do_reset();
        run_instr(J, 0, 0, 0, stop);
        bus.op = SW;
        mem_wait(0, 0, err);
        step(w_decode, "sw_decode");
        step(w_memadr, "sw_memadr");
        bus.mem_ready = 1'b0;
        step(w_memwr(0), "sw_memwr");
        reset_n = 1'b0;
        step(w_memwr(0), "sw_memwr_rst");
        reset_n = 1'b1;
        step(W_IDLE, "sw_rst_idle");
        for (int n = 0; n < 300; n++) begin
            o = ops[$urandom_range(0, 5)];
            if ($urandom_range(0, 11) == 0) begin
                o = 6'($urandom);
                if (legal(o)) o = 6'b111111;
            end
            fw = $urandom_range(0, 9) == 0 ? $urandom_range(T, T + 2) : $urandom_range(0, T - 1);
            mw = $urandom_range(0, 9) == 0 ? $urandom_range(T, T + 2) : $urandom_range(0, T - 1);
            run_instr(o, 1'($urandom), fw, mw, stop);
            if (stop) do_reset();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
